ask_demodulator: RTL
====================

# ask_demodulator

Recovers the on-off-keyed data bit from the 8-bit ADC samples of an ASK carrier. It is the receive-side counterpart of the ASK modulator and sits between the ADC front end and the data sink. Samples are rectified about mid-scale and peak-held over fixed windows spanning at least one carrier period. The resulting envelope is sliced with hysteresis and a multi-window confirmation filter to produce a clean `data_out`.

## Interface
- `WIN_LEN`, 10: window length in sys_clk cycles; ≥ carrier period (65536/BASE_PHASE); legal range 2..255.
- `TH_HIGH`, 48: envelope level at or above which a window votes "1"; 7-bit.
- `TH_LOW`, 24: envelope level at or below which a window votes "0"; must be < TH_HIGH.
- `CONFIRM`, 2: consecutive qualifying windows required to change `data_out`; range 1..15.

- `sys_clk` input 1: single system clock, 50 MHz, rising edge.
- `sys_rst_n` input 1: asynchronous, active-low reset.
- `ad_data` input 8: ADC sample, offset binary, mid-scale 128 = zero.
- `ad_clk` output 1: ADC sample clock, `~sys_clk` (combinational), toggles during reset.
- `data_out` output 1: recovered bit, registered.
- `data_edge` output 1: one-cycle pulse whenever `data_out` changes.
- `env_level` output 7: most recent window peak magnitude.
- `env_valid` output 1: one-cycle pulse when `env_level` updates.

## Operation
- Stage 1: `ad_q <= ad_data` every cycle.
- Stage 2: `mag_q <= |ad_q − 128|`, computed 9-bit signed; 128 (ad_q = 0) saturates to 127.
- Window:
  - `win_cnt` runs 0..WIN_LEN−1 and wraps.
  - When `win_cnt == WIN_LEN−1`: `env_level <= max(run_max, mag_q)`, `run_max <= 0`, `env_valid <= 1`.
  - Otherwise: `run_max <= max(run_max, mag_q)`, `env_valid <= 0`.
  - The sample in the final cycle is included; no sample is dropped or double-counted across windows.
- Slicer FSM: 2-bit state, 4-bit `conf_cnt`. Evaluated only in cycles with `env_valid == 1`; otherwise it holds.
  - LOW (`data_out` = 0):
    - If `env_level ≥ TH_HIGH`: `conf_cnt = 1`. If CONFIRM == 1, go to HIGH; else go to PEND_H.
    - Otherwise stay.
  - PEND_H (`data_out` = 0):
    - If `env_level ≥ TH_HIGH`: increment `conf_cnt`. When it reaches CONFIRM, go to HIGH.
    - Otherwise return to LOW, `conf_cnt = 0`.
  - HIGH (`data_out` = 1): mirror of LOW, using `env_level ≤ TH_LOW`; go to PEND_L, or directly to LOW when CONFIRM == 1.
  - PEND_L (`data_out` = 1): mirror of PEND_H; on a non-qualifying window, return to HIGH.
  - Levels strictly between TH_LOW and TH_HIGH never qualify. They abort a pending transition and otherwise hold the current state.
- `data_out` and `data_edge` are registered from the FSM's next-state decode.
- `data_edge = 1` for exactly the cycle in which `data_out` first shows its new value.

## Timing
- Reset values (asynchronous, immediate):
  - Outputs: `data_out` 0, `data_edge` 0, `env_level` 0, `env_valid` 0.
  - Internal: `ad_q` 128, `mag_q` 0, `run_max` 0, `win_cnt` 0, state LOW, `conf_cnt` 0.
- After reset release:
  - First `env_valid` pulse follows the WIN_LEN-th rising edge.
  - Subsequent pulses repeat every WIN_LEN cycles.
- Sample pipeline: `ad_data` at edge n affects `mag_q` at edge n+1 and `run_max`/`env_level` at edge n+2 at the earliest.
- `data_out` update: the edge after the `env_valid` cycle of the CONFIRM-th qualifying window.
- Worst-case step-to-`data_out` latency: 2 + (CONFIRM+1)·WIN_LEN + 1 cycles. With defaults this is 33 cycles.
- Reset mid-operation:
  - All state is cleared asynchronously.
  - A pending confirmation is discarded.
  - The window restarts at `win_cnt = 0` on release.
- `ad_clk` is unaffected by reset.

## Test plan
- Reset with `ad_data` = 128 constant → all outputs 0. `env_valid` pulses every 10 cycles with `env_level` = 0; `data_out` stays 0.
- Square tone 228/28 alternating each cycle (magnitude 100), starting after reset → `env_level` = 100. `data_out` rises after the 2nd qualifying window; one `data_edge` pulse; latency ≤ 33 cycles.
- Tone then drop to `ad_data` = 128 → `data_out` falls after two windows with `env_level` = 0; one `data_edge` pulse.
- Tone magnitude 36 (between thresholds) from LOW → `data_out` stays 0. From HIGH with magnitude 36 → `data_out` stays 1. In both cases no `data_edge` pulse.
- Single-window burst of magnitude 100 in an otherwise silent stream → state goes LOW→PEND_H→LOW; `data_out` remains 0. Also check `ad_data` = 0 → `env_level` = 127 (saturation).
- Assert `sys_rst_n` low for 3 cycles while in PEND_H → outputs clear immediately. After release, the next `env_valid` pulse arrives exactly WIN_LEN edges later.

Source files
------------

// File: rtl/ask_demodulator_if.sv
// ADC-side sample bus and recovered-data outputs of the ASK receiver.
// The slave side is the demodulator; the master side feeds samples.
interface ask_demodulator_if;
    logic [7:0] ad_data;
    logic       ad_clk;
    logic       data_out;
    logic       data_edge;
    logic [6:0] env_level;
    logic       env_valid;

    modport master (
        output ad_data,
        input  ad_clk, data_out, data_edge, env_level, env_valid
    );

    modport slave (
        input  ad_data,
        output ad_clk, data_out, data_edge, env_level, env_valid
    );
endinterface

// File: rtl/ask_demodulator.sv
// ASK receiver: rectify about mid-scale, peak-hold per window, then
// slice the envelope with hysteresis and multi-window confirmation.
module ask_demodulator #(
    parameter int unsigned WIN_LEN = 10,
    parameter int unsigned TH_HIGH = 48,
    parameter int unsigned TH_LOW  = 24,
    parameter int unsigned CONFIRM = 2
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    ask_demodulator_if.slave bus
);

    typedef enum logic [1:0] {
        S_LOW,
        S_PEND_H,
        S_HIGH,
        S_PEND_L
    } state_t;

    localparam logic [7:0] WIN_LAST = 8'(WIN_LEN - 1);
    localparam logic [6:0] TH_H     = 7'(TH_HIGH);
    localparam logic [6:0] TH_L     = 7'(TH_LOW);
    localparam logic [3:0] CONF     = 4'(CONFIRM);

    logic [7:0] ad_q;
    logic [6:0] mag_q;
    logic [6:0] run_max;
    logic [7:0] win_cnt;
    logic [6:0] env_level;
    logic       env_valid;
    logic       data_out;
    logic       data_edge;

    state_t     state, state_n;
    logic [3:0] conf_cnt, conf_n;
    logic       out_n;

    logic [8:0] diff;
    logic [8:0] abs_v;
    logic [6:0] mag_d;
    logic [6:0] peak;
    logic       hi_q;
    logic       lo_q;
    logic [3:0] conf_inc;

    assign bus.ad_clk    = ~sys_clk;
    assign bus.data_out  = data_out;
    assign bus.data_edge = data_edge;
    assign bus.env_level = env_level;
    assign bus.env_valid = env_valid;

    // |ad_q - 128|; a zero sample gives 128, which saturates to 127
    assign diff  = {1'b0, ad_q} - 9'd128;
    assign abs_v = diff[8] ? (~diff + 9'd1) : diff;
    assign mag_d = abs_v[7] ? 7'd127 : abs_v[6:0];
    assign peak  = (mag_q > run_max) ? mag_q : run_max;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ad_q      <= 8'd128;
            mag_q     <= '0;
            run_max   <= '0;
            win_cnt   <= '0;
            env_level <= '0;
            env_valid <= 1'b0;
        end else begin
            ad_q  <= bus.ad_data;
            mag_q <= mag_d;
            if (win_cnt == WIN_LAST) begin
                win_cnt   <= '0;
                env_level <= peak;
                run_max   <= '0;
                env_valid <= 1'b1;
            end else begin
                win_cnt   <= win_cnt + 8'd1;
                run_max   <= peak;
                env_valid <= 1'b0;
            end
        end
    end

    assign hi_q     = (env_level >= TH_H);
    assign lo_q     = (env_level <= TH_L);
    assign conf_inc = conf_cnt + 4'd1;

    always_comb begin
        state_n = state;
        conf_n  = conf_cnt;
        if (env_valid) begin
            unique case (state)
                S_LOW: begin
                    if (hi_q) begin
                        state_n = (CONF == 4'd1) ? S_HIGH : S_PEND_H;
                        conf_n  = (CONF == 4'd1) ? 4'd0 : 4'd1;
                    end
                end
                S_PEND_H: begin
                    if (hi_q) begin
                        state_n = (conf_inc == CONF) ? S_HIGH : S_PEND_H;
                        conf_n  = (conf_inc == CONF) ? 4'd0 : conf_inc;
                    end else begin
                        state_n = S_LOW;
                        conf_n  = 4'd0;
                    end
                end
                S_HIGH: begin
                    if (lo_q) begin
                        state_n = (CONF == 4'd1) ? S_LOW : S_PEND_L;
                        conf_n  = (CONF == 4'd1) ? 4'd0 : 4'd1;
                    end
                end
                S_PEND_L: begin
                    if (lo_q) begin
                        state_n = (conf_inc == CONF) ? S_LOW : S_PEND_L;
                        conf_n  = (conf_inc == CONF) ? 4'd0 : conf_inc;
                    end else begin
                        state_n = S_HIGH;
                        conf_n  = 4'd0;
                    end
                end
                default: begin
                    state_n = S_LOW;
                    conf_n  = 4'd0;
                end
            endcase
        end
        out_n = (state_n == S_HIGH) || (state_n == S_PEND_L);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= S_LOW;
            conf_cnt  <= '0;
            data_out  <= 1'b0;
            data_edge <= 1'b0;
        end else begin
            state     <= state_n;
            conf_cnt  <= conf_n;
            data_out  <= out_n;
            data_edge <= out_n ^ data_out;
        end
    end

endmodule
